// File: rtl/audio_adc_rx_if.sv
// Stereo sample stream between the ADC receiver and its consumer.
// The receiver drives the head pair (show-ahead) and the consumer acknowledges it.
interface audio_adc_rx_if #(
  parameter int DATA_WIDTH = 16
) ();
  logic                  sample_valid;
  logic                  sample_ready;
  logic [DATA_WIDTH-1:0] sample_left;
  logic [DATA_WIDTH-1:0] sample_right;

  modport master (output sample_valid, output sample_left, output sample_right,
                  input  sample_ready);
  modport slave  (input  sample_valid, input  sample_left, input  sample_right,
                  output sample_ready);
endinterface

// File: rtl/audio_adc_rx.sv
// WM8731 I2S ADC receiver: oversampled BCLK/ADCLRCK/ADCDAT deserializer feeding
// a stereo-pair FIFO drained over a valid/ready stream.
module audio_adc_rx #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk_clk,
  input  logic                        reset_reset_n,
  input  logic                        enable,
  input  logic                        audio_BCLK,
  input  logic                        audio_ADCLRCK,
  input  logic                        audio_ADCDAT,
  audio_adc_rx_if.master              sample,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  input  logic                        clear_overflow
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] DW_C    = CW'(DATA_WIDTH);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_HUNT, S_LEFT, S_RIGHT} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] left;
    logic [DATA_WIDTH-1:0] right;
  } pair_t;

  logic r_bclk_s1, r_bclk_s2, r_bclk_hist;
  logic r_lr_s1, r_lr_s2, r_dat_s1, r_dat_s2;
  logic w_rise;

  // All three inputs see the same sync depth so the data bit lines up with the edge.
  // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_bclk_s1   <= 1'b0;
      r_bclk_s2   <= 1'b0;
      r_bclk_hist <= 1'b0;
      r_lr_s1     <= 1'b0;
      r_lr_s2     <= 1'b0;
      r_dat_s1    <= 1'b0;
      r_dat_s2    <= 1'b0;
    end else begin
      r_bclk_s1   <= audio_BCLK;
      r_bclk_s2   <= r_bclk_s1;
      r_bclk_hist <= r_bclk_s2;
      r_lr_s1     <= audio_ADCLRCK;
      r_lr_s2     <= r_lr_s1;
      r_dat_s1    <= audio_ADCDAT;
      r_dat_s2    <= r_dat_s1;
    end
  end

  assign w_rise = r_bclk_s2 & ~r_bclk_hist;

  state_t                r_state, w_state_nxt;
  logic                  r_lr_prev;
  logic [DATA_WIDTH-1:0] r_shift, r_left_hold, w_word;
  logic [CW-1:0]         r_count;
  logic                  w_shift_en, w_end_left, w_end_right;
  logic                  r_push;
  pair_t                 r_push_pair;

  // Short words end up MSB-aligned with zero padding.
  assign w_word = r_shift << (DW_C - r_count);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_en  = 1'b0;
    w_end_left  = 1'b0;
    w_end_right = 1'b0;
    if (!enable) begin
      w_state_nxt = S_HUNT;
    end else if (w_rise) begin
      unique case (r_state)
        S_HUNT:  if (r_lr_prev && !r_lr_s2) w_state_nxt = S_LEFT;
        S_LEFT: begin
          if (r_lr_s2 == r_lr_prev) begin
            w_shift_en = 1'b1;
          end else if (r_lr_s2) begin
            w_end_left  = 1'b1;
            w_state_nxt = S_RIGHT;
          end
        end
        S_RIGHT: begin
          if (r_lr_s2 == r_lr_prev) begin
            w_shift_en = 1'b1;
          end else if (!r_lr_s2) begin
            w_end_right = 1'b1;
            w_state_nxt = S_LEFT;
          end
        end
        default: w_state_nxt = S_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_state     <= S_HUNT;
      r_lr_prev   <= 1'b1;
      r_shift     <= '0;
      r_count     <= '0;
      r_left_hold <= '0;
      r_push      <= 1'b0;
      r_push_pair <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_push  <= w_end_right;
      if (w_rise) r_lr_prev <= r_lr_s2;
      if (w_end_left) r_left_hold <= w_word;
      if (w_end_right) r_push_pair <= '{left: r_left_hold, right: w_word};
      // Delay-slot bits and anything seen while hunting or disabled never reach a word.
      if (!enable || r_state == S_HUNT || w_end_left || w_end_right) begin
        r_shift <= '0;
        r_count <= '0;
      end else if (w_shift_en && r_count < DW_C) begin
        r_shift <= (r_shift << 1) | DATA_WIDTH'(r_dat_s2);
        r_count <= r_count + 1'b1;
      end
    end
  end

  pair_t       r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr_ptr, r_rd_ptr, w_level;
  logic        w_full, w_valid, w_pop, w_wr_en;
  logic        r_overflow;
  pair_t       w_head;

  assign w_level = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_level == DEPTH_C);
  assign w_valid = (w_level != '0);
  assign w_pop   = w_valid & sample.sample_ready;
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign w_wr_en = r_push & enable & (~w_full | w_pop);

  // NOTE: the storage array carries no reset; outputs are gated by valid instead.
  always_ff @(posedge clk_clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= r_push_pair;
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      if (r_push && enable && w_full && !w_pop) r_overflow <= 1'b1;
      else if (clear_overflow)                  r_overflow <= 1'b0;
    end
  end

  assign w_head              = r_mem[r_rd_ptr[AW-1:0]];
  assign sample.sample_valid = w_valid;
  assign sample.sample_left  = w_valid ? w_head.left  : '0;
  assign sample.sample_right = w_valid ? w_head.right : '0;
  assign fifo_level          = w_level;
  assign overflow            = r_overflow;

endmodule

// File: tb/tb_audio_adc_rx.sv
// Scoreboard bench for audio_adc_rx: an I2S BFM at BCLK = clk/16 issues frames,
// expected pairs are queued at issue and a monitor compares them on every pop.
module tb_audio_adc_rx;
  localparam int DW    = 16;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       bclk = 1'b0;
  logic       lrck = 1'b1;
  logic       dat = 1'b0;
  logic       clear_ovf = 1'b0;
  logic [3:0] level;
  logic       ovf;

  audio_adc_rx_if #(.DATA_WIDTH(DW)) sif ();

  audio_adc_rx #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk_clk        (clk),
    .reset_reset_n  (rst_n),
    .enable         (enable),
    .audio_BCLK     (bclk),
    .audio_ADCLRCK  (lrck),
    .audio_ADCDAT   (dat),
    .sample         (sif.master),
    .fifo_level     (level),
    .overflow       (ovf),
    .clear_overflow (clear_ovf)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_bad    = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_pair;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted head pair must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && sif.sample_valid && sif.sample_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_bad++;
        $display("FAIL unexpected_pair: got %h expected none", {sif.sample_left, sif.sample_right});
      end else begin
        exp_pair = sb.pop_front();
        check("pair", {sif.sample_left, sif.sample_right}, exp_pair);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic align();
    @(posedge clk);
    #3;
  endtask

  task automatic slot(input logic lr, input logic d);
    bclk = 1'b0; lrck = lr; dat = d;
    #80;
    bclk = 1'b1;
    #80;
  endtask

  // Slot 0 is the I2S delay slot; slot s>=1 carries word bit 32-s (MSB first).
  task automatic half(input logic lr, input logic [31:0] w, input int from, input int to);
    for (int s = from; s < to; s++) slot(lr, (s == 0) ? 1'b0 : w[32-s]);
  endtask

  task automatic frame(input logic [31:0] l, input logic [31:0] r, input int h);
    half(1'b0, l, 0, h);
    half(1'b1, r, 0, h);
  endtask

  // Falling LRCK edge that completes the previous pair; N is the next clk edge.
  task automatic close_frame(input bit chk_timing, input bit pop_at_push);
    bclk = 1'b0; lrck = 1'b0; dat = 1'b0;
    #80;
    bclk = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    if (chk_timing) check("valid_before_n3", sif.sample_valid, 0);
    if (pop_at_push) sif.sample_ready = 1'b1;
    @(posedge clk); #1;
    if (chk_timing) check("valid_at_n3", sif.sample_valid, 1);
    if (pop_at_push) begin
      sif.sample_ready = 1'b0;
      check("level_full_pushpop", level, 8);
      check("ovf_full_pushpop", ovf, 0);
    end
    #80;
  endtask

  task automatic to_hunt();
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1 enable = 1'b1;
  endtask

  task automatic drain();
    sif.sample_ready = 1'b1;
    for (int i = 0; i < 200 && level != 0; i++) @(posedge clk);
    #1;
    check("drain_level", level, 0);
    check("drain_sb_empty", sb.size(), 0);
    sif.sample_ready = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, sif.sample_valid, 0);
    check({tag, "_left"},  sif.sample_left, 0);
    check({tag, "_right"}, sif.sample_right, 0);
    check({tag, "_level"}, level, 0);
    check({tag, "_ovf"},   ovf, 0);
  endtask

  logic [15:0] l16, r16;

  initial begin
    sif.sample_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    rst_n = 1'b1;
    enable = 1'b1;

    // 32-bit slots, 16 kept; also the N+3 valid latency.
    sif.sample_ready = 1'b1;
    align();
    half(1'b1, 32'h0, 0, 32);
    frame(32'hA5A5_1234, 32'h3C3C_5678, 32);
    sb.push_back(32'hA5A5_3C3C);
    close_frame(1, 0);
    to_hunt();
    drain();

    // 12-bit words in 16-slot halves: MSB-aligned, zero padded.
    sif.sample_ready = 1'b1;
    align();
    half(1'b1, 32'h0, 0, 16);
    frame(32'hABC << 20, 32'h123 << 20, 16);
    sb.push_back(32'hABC0_1230);
    frame(32'hFFF << 20, 32'h001 << 20, 16);
    sb.push_back(32'hFFF0_0010);
    close_frame(0, 0);
    to_hunt();
    drain();

    // Nine frames into an 8-deep FIFO with no reader: frame 9 is dropped.
    align();
    half(1'b1, 32'h0, 0, 17);
    for (int i = 0; i < 9; i++) begin
      l16 = 16'h0101 * 16'(i + 1);
      r16 = ~l16;
      frame({l16, 16'h0}, {r16, 16'h0}, 17);
      if (i < 8) sb.push_back({l16, r16});
    end
    close_frame(0, 0);
    repeat (4) @(posedge clk);
    #1;
    check("fill_level", level, 8);
    check("fill_ovf", ovf, 1);
    check("fill_head", {sif.sample_left, sif.sample_right}, 32'h0101_FEFE);
    clear_ovf = 1'b1;
    @(posedge clk); #1 clear_ovf = 1'b0;
    check("ovf_cleared", ovf, 0);
    to_hunt();
    drain();

    // At full, pop and push in the same cycle: nothing lost.
    align();
    half(1'b1, 32'h0, 0, 17);
    for (int i = 0; i < 9; i++) begin
      l16 = 16'h1000 + 16'(i * 16'h0111);
      r16 = 16'h8000 | 16'(i);
      frame({l16, 16'h0}, {r16, 16'h0}, 17);
      sb.push_back({l16, r16});
    end
    close_frame(0, 1);
    to_hunt();
    drain();

    // enable dropped mid-left: that frame is discarded, stored pairs survive.
    align();
    half(1'b1, 32'h0, 0, 17);
    frame(32'h1111_0000, 32'h2222_0000, 17);
    frame(32'h3333_0000, 32'h4444_0000, 17);
    half(1'b0, 32'h5555_0000, 0, 6);
    check("en_level_before", level, 2);
    enable = 1'b0;
    repeat (4) @(posedge clk);
    #1 enable = 1'b1;
    align();
    half(1'b0, 32'h5555_0000, 6, 17);
    half(1'b1, 32'h6666_0000, 0, 17);
    check("en_level_discard", level, 2);
    frame(32'h7777_0000, 32'h8888_0000, 17);
    close_frame(0, 0);
    to_hunt();
    check("en_level_after", level, 3);
    sb.push_back(32'h1111_2222);
    sb.push_back(32'h3333_4444);
    sb.push_back(32'h7777_8888);
    drain();

    // Reset mid-frame for two cycles, then recapture from a fresh frame start.
    align();
    half(1'b1, 32'h0, 0, 17);
    frame(32'h9999_0000, 32'hAAAA_0000, 17);
    half(1'b0, 32'hBBBB_0000, 0, 17);
    half(1'b1, 32'hCCCC_0000, 0, 5);
    check("rst_level_before", level, 1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 check_zero("midreset");
    @(posedge clk); #1 rst_n = 1'b1;
    align();
    half(1'b1, 32'hCCCC_0000, 5, 17);
    check("rst_no_push", level, 0);
    frame(32'hDDDD_0000, 32'hEEEE_0000, 17);
    close_frame(0, 0);
    to_hunt();
    check("rst_level_after", level, 1);
    sb.push_back(32'hDDDD_EEEE);
    drain();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
